// File: rtl/keypad_pkg.sv
// Shared types for the keypad scanner: frame-result and scan-state encodings,
// plus the key-code width helper.
package keypad_pkg;

    typedef enum logic [1:0] {
        RES_NONE   = 2'd0,
        RES_SINGLE = 2'd1,
        RES_MULTI  = 2'd2
    } frame_res_t;

    typedef enum logic {
        ST_DWELL   = 1'b0,
        ST_ADVANCE = 1'b1
    } scan_state_t;

    function automatic int key_width(input int rows, input int cols);
        return (rows * cols > 1) ? $clog2(rows * cols) : 1;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debouncer: tracks consecutive identical frame results and emits
// press events. KEYPAD_SCANNER_REPEAT_EN adds auto-repeat while a key is held.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE      = 4,
`ifdef KEYPAD_SCANNER_REPEAT_EN
    parameter int REPEAT_FRAMES = 50,
`endif
    parameter int KEY_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             close,
    input  frame_res_t       res,
    input  logic [KEY_W-1:0] code,
    output frame_res_t       stable,
    output logic             ev_pulse,
    output logic [KEY_W-1:0] ev_code
);

    localparam logic [3:0] DB = 4'(DEBOUNCE);

    frame_res_t       prev_res_r;
    frame_res_t       stable_r;
    logic [KEY_W-1:0] prev_code_r;
    logic [KEY_W-1:0] stable_code_r;
    logic [KEY_W-1:0] ev_code_r;
    logic [3:0]       cnt_r;
    logic             ev_r;

    logic             same_s;
    logic [3:0]       cnt_nx_s;
    logic             take_s;
    logic             press_s;
    logic             fire_s;

    // Compare the closing frame with its predecessor and decide whether it becomes stable.
    always_comb begin
        same_s   = (res == prev_res_r) && (code == prev_code_r);
        cnt_nx_s = !same_s ? 4'd1 : ((cnt_r == DB) ? cnt_r : cnt_r + 4'd1);
        take_s   = (cnt_nx_s == DB) && ((res != stable_r) || (code != stable_code_r));
        press_s  = take_s && (stable_r == RES_NONE) && (res == RES_SINGLE);
    end

`ifdef KEYPAD_SCANNER_REPEAT_EN
    localparam int PW = $clog2(REPEAT_FRAMES + 1);

    logic [PW-1:0] rep_r;
    logic          rep_hit_s;

    // A repeat fires only while the stable state stays on the same single key.
    always_comb begin
        rep_hit_s = !take_s && (stable_r == RES_SINGLE) && (rep_r == PW'(REPEAT_FRAMES - 1));
        fire_s    = press_s || rep_hit_s;
    end

    // Repeat counter: counts frame closes since the last stable change or repeat.
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_r <= '0;
        end else if (close) begin
            if (take_s || (stable_r != RES_SINGLE) || rep_hit_s) begin
                rep_r <= '0;
            end else begin
                rep_r <= rep_r + PW'(1);
            end
        end
    end
`else
    // Without auto-repeat only the NONE -> SINGLE transition produces an event.
    always_comb begin
        fire_s = press_s;
    end
`endif

    // Debounce history, stable state and registered event strobe, all updated at frame close.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_res_r    <= RES_NONE;
            prev_code_r   <= '0;
            cnt_r         <= 4'd0;
            stable_r      <= RES_NONE;
            stable_code_r <= '0;
            ev_r          <= 1'b0;
            ev_code_r     <= '0;
        end else begin
            ev_r <= 1'b0;
            if (close) begin
                prev_res_r  <= res;
                prev_code_r <= code;
                cnt_r       <= cnt_nx_s;
                if (take_s) begin
                    stable_r      <= res;
                    stable_code_r <= code;
                end
                ev_r      <= fire_s;
                ev_code_r <= take_s ? code : stable_code_r;
            end
        end
    end

    assign stable   = stable_r;
    assign ev_pulse = ev_r;
    assign ev_code  = ev_code_r;

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: row strobing, column synchronisation, frame accumulation
// and valid/ready event output. KEYPAD_SCANNER_REPEAT_EN enables auto-repeat.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS          = 4,
    parameter int COLS          = 4,
    parameter int SCAN_DIV      = 1000,
    parameter int DEBOUNCE      = 4,
`ifdef KEYPAD_SCANNER_REPEAT_EN
    parameter int REPEAT_FRAMES = 50,
`endif
    parameter int KEY_W         = key_width(ROWS, COLS)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [ROWS-1:0]  row_drv,
    input  logic [COLS-1:0]  col_in,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    input  logic             key_ready,
    output logic             key_held,
    output logic             key_multi,
    output logic             overrun
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(SCAN_DIV - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    logic [COLS-1:0]  col_meta_r;
    logic [COLS-1:0]  col_sync_r;
    scan_state_t      state_r;
    scan_state_t      state_nx;
    logic [DW-1:0]    cnt_r;
    logic [DW-1:0]    cnt_nx;
    logic [RW-1:0]    row_r;
    logic [RW-1:0]    row_nx;
    logic [ROWS-1:0]  row_drv_r;
    logic             sample_s;
    logic             advance_s;
    logic             close_s;

    logic [1:0]       row_hits_s;
    logic [CW-1:0]    first_col_s;
    logic [2:0]       sum_s;
    logic [1:0]       hits_sat_s;
    logic [KEY_W-1:0] hit_code_s;
    logic [1:0]       frame_hits_r;
    logic [KEY_W-1:0] first_code_r;
    frame_res_t       res_s;
    logic [KEY_W-1:0] res_code_s;

    frame_res_t       stable_s;
    logic             ev_s;
    logic [KEY_W-1:0] ev_code_s;
    logic [KEY_W-1:0] key_code_r;
    logic             key_valid_r;
    logic             key_held_r;
    logic             key_multi_r;
    logic             overrun_r;

    // Two-flop synchroniser for the asynchronous column pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_meta_r <= '0;
            col_sync_r <= '0;
        end else begin
            col_meta_r <= col_in;
            col_sync_r <= col_meta_r;
        end
    end

    // Scan FSM state register with dwell counter and row index.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_DWELL;
            cnt_r   <= '0;
            row_r   <= '0;
        end else begin
            state_r <= state_nx;
            cnt_r   <= cnt_nx;
            row_r   <= row_nx;
        end
    end

    // Scan FSM next-state logic.
    always_comb begin
        state_nx = state_r;
        cnt_nx   = cnt_r;
        row_nx   = row_r;
        case (state_r)
            ST_DWELL: begin
                if (cnt_r == LAST) begin
                    state_nx = ST_ADVANCE;
                end else begin
                    cnt_nx = cnt_r + DW'(1);
                end
            end
            ST_ADVANCE: begin
                state_nx = ST_DWELL;
                cnt_nx   = '0;
                row_nx   = (row_r == LAST_ROW) ? '0 : row_r + RW'(1);
            end
            default: begin
                state_nx = ST_DWELL;
                cnt_nx   = '0;
                row_nx   = '0;
            end
        endcase
    end

    // Scan FSM outputs: the sample strobe lands on the last dwell cycle, after sync settles.
    always_comb begin
        sample_s  = (state_r == ST_DWELL) && (cnt_r == LAST);
        advance_s = (state_r == ST_ADVANCE);
        close_s   = advance_s && (row_r == LAST_ROW);
    end

    // One-hot row strobe rotates on every ADVANCE.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_drv_r <= ROWS'(1'b1);
        end else if (advance_s) begin
            row_drv_r <= {row_drv_r[ROWS-2:0], row_drv_r[ROWS-1]};
        end
    end

    // Per-row hit count (saturating at 2) and lowest asserted column.
    always_comb begin
        row_hits_s  = 2'd0;
        first_col_s = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            row_hits_s  = (col_sync_r[c] && (row_hits_s != 2'd2)) ? row_hits_s + 2'd1 : row_hits_s;
            first_col_s = col_sync_r[c] ? CW'(c) : first_col_s;
        end
        sum_s      = {1'b0, frame_hits_r} + {1'b0, row_hits_s};
        hits_sat_s = (sum_s >= 3'd2) ? 2'd2 : sum_s[1:0];
        hit_code_s = KEY_W'(row_r) * KEY_W'(COLS) + KEY_W'(first_col_s);
    end

    // Frame accumulator; rows are visited in order so the first hit is the lowest row.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_hits_r <= 2'd0;
            first_code_r <= '0;
        end else if (close_s) begin
            frame_hits_r <= 2'd0;
            first_code_r <= '0;
        end else if (sample_s) begin
            frame_hits_r <= hits_sat_s;
            if ((frame_hits_r == 2'd0) && (row_hits_s != 2'd0)) begin
                first_code_r <= hit_code_s;
            end
        end
    end

    // Frame result; the code is normalised to zero unless exactly one key was seen.
    always_comb begin
        case (frame_hits_r)
            2'd0: begin
                res_s      = RES_NONE;
                res_code_s = '0;
            end
            2'd1: begin
                res_s      = RES_SINGLE;
                res_code_s = first_code_r;
            end
            default: begin
                res_s      = RES_MULTI;
                res_code_s = '0;
            end
        endcase
    end

    keypad_debounce #(
        .DEBOUNCE      (DEBOUNCE),
`ifdef KEYPAD_SCANNER_REPEAT_EN
        .REPEAT_FRAMES (REPEAT_FRAMES),
`endif
        .KEY_W         (KEY_W)
    ) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .close    (close_s),
        .res      (res_s),
        .code     (res_code_s),
        .stable   (stable_s),
        .ev_pulse (ev_s),
        .ev_code  (ev_code_s)
    );

    // Stable-state flags, one cycle behind the debouncer.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_held_r  <= 1'b0;
            key_multi_r <= 1'b0;
        end else begin
            key_held_r  <= (stable_s == RES_SINGLE);
            key_multi_r <= (stable_s == RES_MULTI);
        end
    end

    // Event handshake: a consume in the same cycle frees the slot for the new event.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_code_r  <= '0;
            key_valid_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else if (ev_s) begin
            if (!key_valid_r || key_ready) begin
                key_code_r  <= ev_code_s;
                key_valid_r <= 1'b1;
            end else begin
                overrun_r <= 1'b1;
            end
        end else if (key_valid_r && key_ready) begin
            key_valid_r <= 1'b0;
        end
    end

    assign row_drv   = row_drv_r;
    assign key_code  = key_code_r;
    assign key_valid = key_valid_r;
    assign key_held  = key_held_r;
    assign key_multi = key_multi_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (4x4, SCAN_DIV=4, DEBOUNCE=2, 20-cycle frames).
// With KEYPAD_SCANNER_REPEAT_EN a second instance with REPEAT_FRAMES=3 is exercised.
module tb_keypad_scanner;

    localparam int FR = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_ready;
    logic [15:0] keys;
    logic [3:0]  row_drv;
    logic [3:0]  col_in;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic        key_multi;
    logic        overrun;

    int          checks = 0;
    int          errors = 0;
    int          ev_cnt = 0;
    logic [3:0]  ev_code = 4'd0;
    int          cyc = 0;

    always #5 clk = ~clk;

    // Keypad model: key index r*4+c connects row r to column c.
    function automatic logic [3:0] pad(input logic [15:0] k, input logic [3:0] rd);
        logic [3:0] c;
        c = 4'd0;
        for (int r = 0; r < 4; r++) begin
            if (rd[r]) c = c | k[r*4 +: 4];
        end
        return c;
    endfunction

    assign col_in = pad(keys, row_drv);

    keypad_scanner #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(2)
    ) dut (
        .clk(clk), .rst(rst), .row_drv(row_drv), .col_in(col_in),
        .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
        .key_held(key_held), .key_multi(key_multi), .overrun(overrun)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && key_valid && key_ready) begin
            ev_cnt  <= ev_cnt + 1;
            ev_code <= key_code;
        end
    end

`ifdef KEYPAD_SCANNER_REPEAT_EN
    logic [3:0] rep_row_drv;
    logic [3:0] rep_col_in;
    logic [3:0] rep_key_code;
    logic       rep_valid;
    logic       rep_ready;
    logic       rep_held;
    logic       rep_multi;
    logic       rep_overrun;
    int         rep_cnt = 0;
    int         rep_time [256];
    logic [3:0] rep_codes [256];

    assign rep_col_in = pad(keys, rep_row_drv);

    keypad_scanner #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(2), .REPEAT_FRAMES(3)
    ) dut_rep (
        .clk(clk), .rst(rst), .row_drv(rep_row_drv), .col_in(rep_col_in),
        .key_code(rep_key_code), .key_valid(rep_valid), .key_ready(rep_ready),
        .key_held(rep_held), .key_multi(rep_multi), .overrun(rep_overrun)
    );

    always @(posedge clk) begin
        if (!rst && rep_valid && rep_ready) begin
            if (rep_cnt < 256) begin
                rep_time[rep_cnt]  <= cyc;
                rep_codes[rep_cnt] <= rep_key_code;
            end
            rep_cnt <= rep_cnt + 1;
        end
    end
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int base;
        int w;
        rst       = 1'b1;
        keys      = 16'd0;
        key_ready = 1'b0;
`ifdef KEYPAD_SCANNER_REPEAT_EN
        rep_ready = 1'b1;
`endif
        tick(3);
        rst = 1'b0;

        // Reset state and first row step
        check("rst_row_drv",   32'(row_drv), 32'd1);
        check("rst_key_valid", 32'(key_valid), 32'd0);
        check("rst_key_held",  32'(key_held), 32'd0);
        check("rst_key_multi", 32'(key_multi), 32'd0);
        check("rst_overrun",   32'(overrun), 32'd0);
        check("rst_key_code",  32'(key_code), 32'd0);
        tick(4);
        check("row_drv_4cyc",  32'(row_drv), 32'd1);
        tick(1);
        check("row_drv_5cyc",  32'(row_drv), 32'd2);

        // Clean press of row 1 / col 2
        key_ready = 1'b1;
        base = ev_cnt;
        keys[6] = 1'b1;
        w = 0;
        while (!key_held && w < 3 * FR + 3) begin
            tick(1);
            w++;
        end
        check("clean_held_latency", 32'(key_held), 32'd1);
        tick(4 * FR - w);
        check("clean_ev_count", 32'(ev_cnt - base), 32'd1);
        check("clean_ev_code",  32'(ev_code), 32'd6);
        check("clean_held",     32'(key_held), 32'd1);
        keys = 16'd0;
        tick(4 * FR);
        check("release_held",     32'(key_held), 32'd0);
        check("release_no_event", 32'(ev_cnt - base), 32'd1);

        // Bounce: toggle each frame, then hold
        base = ev_cnt;
        for (int i = 0; i < 5; i++) begin
            keys[6] = (i % 2 == 0);
            tick(FR);
        end
        check("bounce_quiet", 32'(ev_cnt - base), 32'd0);
        tick(3 * FR);
        check("bounce_ev_count", 32'(ev_cnt - base), 32'd1);
        check("bounce_ev_code",  32'(ev_code), 32'd6);
        keys = 16'd0;
        tick(4 * FR);

        // Multi-key, then MULTI -> SINGLE, then release
        base = ev_cnt;
        keys[0]  = 1'b1;
        keys[15] = 1'b1;
        tick(4 * FR);
        check("multi_flag",     32'(key_multi), 32'd1);
        check("multi_not_held", 32'(key_held), 32'd0);
        check("multi_no_event", 32'(ev_cnt - base), 32'd0);
        keys[15] = 1'b0;
        tick(4 * FR);
        check("m2s_multi",    32'(key_multi), 32'd0);
        check("m2s_held",     32'(key_held), 32'd1);
        check("m2s_no_event", 32'(ev_cnt - base), 32'd0);
        keys = 16'd0;
        tick(4 * FR);
        check("mrel_held",     32'(key_held), 32'd0);
        check("mrel_no_event", 32'(ev_cnt - base), 32'd0);

        // Backpressure and overrun
        key_ready = 1'b0;
        base = ev_cnt;
        keys[1] = 1'b1;
        tick(4 * FR);
        check("bp_valid",    32'(key_valid), 32'd1);
        check("bp_code1",    32'(key_code), 32'd1);
        check("bp_no_ovr",   32'(overrun), 32'd0);
        keys = 16'd0;
        tick(4 * FR);
        keys[13] = 1'b1;
        tick(4 * FR);
        check("bp_code_kept", 32'(key_code), 32'd1);
        check("bp_overrun",   32'(overrun), 32'd1);
        check("bp_valid2",    32'(key_valid), 32'd1);
        key_ready = 1'b1;
        tick(1);
        key_ready = 1'b0;
        check("bp_valid_clear", 32'(key_valid), 32'd0);
        check("bp_consumed",    32'(ev_cnt - base), 32'd1);
        check("bp_consumed_code", 32'(ev_code), 32'd1);
        check("bp_ovr_sticky",  32'(overrun), 32'd1);
        keys = 16'd0;
        tick(4 * FR);

`ifdef KEYPAD_SCANNER_REPEAT_EN
        // Auto-repeat: hold code 5 for 12 frames
        base = rep_cnt;
        keys[5] = 1'b1;
        tick(12 * FR + 5);
        check("rep_count_ge4", 32'(rep_cnt - base >= 4), 32'd1);
        check("rep_gap1", 32'(rep_time[base+1] - rep_time[base]),   32'(3 * FR));
        check("rep_gap2", 32'(rep_time[base+2] - rep_time[base+1]), 32'(3 * FR));
        check("rep_gap3", 32'(rep_time[base+3] - rep_time[base+2]), 32'(3 * FR));
        for (int i = 0; i < 4; i++) begin
            check("rep_code", 32'(rep_codes[base+i]), 32'd5);
        end
        keys = 16'd0;
        tick(3 * FR);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Parametrised matrix-keypad scanner and encoder.
- Drives one-hot row strobes and samples column inputs. Each full scan frame is debounced across consecutive frames.
- Emits linear key-code press events through a valid/ready handshake.
- Sits between the keypad pins and the command/UI logic. Supersedes the fixed 4x4 combinational-decode encoder.

Parameters:
- ROWS, 4, number of keypad rows (2..8)
- COLS, 4, number of keypad columns (2..8)
- SCAN_DIV, 1000, clock cycles each row is driven (dwell), >= 4
- DEBOUNCE, 4, consecutive identical frame results required before the result is accepted as stable (1..15)
- KEY_W, $clog2(ROWS*COLS), key code width (derived, not overridden)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- row_drv  out  ROWS  one-hot row strobe, active-high
- col_in  in  COLS  raw column inputs, active-high, asynchronous to clk
- key_code  out  KEY_W  code of the pressed key = row*COLS + col
- key_valid  out  1  press event available
- key_ready  in  1  consumer accepts event
- key_held  out  1  debounced state is a single key pressed
- key_multi  out  1  debounced state is two or more keys pressed
- overrun  out  1  sticky; an event was dropped while key_valid was pending

Behaviour:
- Reset values (one cycle of rst, synchronous):
  - row_drv=1 (row 0 driven), scan counter=0.
  - key_code=0, key_valid=0, key_held=0, key_multi=0, overrun=0.
  - Debounce count=0, stable state=NONE.
- Synchroniser: col_in passes through a 2-flop synchroniser before any use.
- Scan FSM, states DWELL and ADVANCE:
  - DWELL counts 0..SCAN_DIV-1.
  - On count SCAN_DIV-1, the synchronised columns are sampled for the current row. The FSM then moves to ADVANCE for 1 cycle.
  - ADVANCE rotates row_drv to the next row (wrap ROWS-1 -> 0), then returns to DWELL with count=0.
- Frame accumulation:
  - Per frame, track the number of asserted sample bits (saturating at 2) and the row/col of the first asserted bit found (lowest row, then lowest column).
  - The frame closes on the ADVANCE that follows the row ROWS-1 sample.
  - Frame result is NONE (0 bits), SINGLE(code) (exactly 1 bit), or MULTI (>= 2 bits).
- Debounce:
  - If frame result equals the previous frame result (code included for SINGLE), increment the count, saturating at DEBOUNCE. Otherwise set the count to 1.
  - When the count reaches DEBOUNCE and the result differs from the stable state, the stable state takes the result.
  - This stable-state update happens in the same cycle as the frame close.
- Outputs from stable state:
  - key_held=1 iff stable state is SINGLE; key_multi=1 iff stable state is MULTI.
  - Both update one cycle after the stable-state change.
- Press event: generated on a stable transition from NONE to SINGLE(c).
  - SINGLE -> SINGLE(other code) without passing NONE does not generate an event.
  - MULTI -> SINGLE does not generate an event.
  - SINGLE -> MULTI -> NONE does not generate an event.
- Handshake:
  - If key_valid=0, the event loads key_code=c and sets key_valid=1 on the next cycle.
  - key_code is stable while key_valid=1.
  - key_valid clears in the cycle after key_valid & key_ready.
  - If a new event arrives while key_valid=1 and key_ready=0: the event is dropped and overrun is set; key_code is unchanged.
  - If key_ready=1 in the same cycle a new event arrives: the old event is consumed, the new one is loaded, and key_valid stays 1.
- Reset mid-frame: the partial frame is discarded and scanning restarts at row 0, count 0.
- Event latency from a clean press: at most DEBOUNCE+1 frames plus 3 cycles. One frame = ROWS*(SCAN_DIV+1) cycles.

Optional Feature:
- Macro KEYPAD_SCANNER_REPEAT_EN, adding parameter REPEAT_FRAMES (default 50).
- With the macro: while the stable state remains SINGLE(c), a repeat event for c is generated every REPEAT_FRAMES frame closes after the initial press. The repeat counter resets on any stable-state change. Repeat events use the same handshake and overrun rules.
- Without the macro: only the NONE -> SINGLE press event exists, and no repeat counter is synthesised.

Decomposition:
- Package keypad_pkg:
  - Frame-result enum: RES_NONE, RES_SINGLE, RES_MULTI.
  - Scan FSM state enum: ST_DWELL, ST_ADVANCE.
  - Function for key_code width.
- Sub-module keypad_debounce: takes a frame result plus code and a frame-close strobe, and produces the stable state and a press-event strobe. It is instantiated once.
- Scanning, synchroniser and handshake stay in the top module.

Test Plan:
All scenarios use ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=2 (frame=20 cycles).
- Reset: hold rst 3 cycles -> row_drv=4'b0001, key_valid=0, key_held=0, overrun=0; row_drv steps 0001->0010 after 5 cycles.
- Clean press: col_in[2] asserted only while row 1 is driven, held for 4 frames, key_ready=1 -> exactly one event with key_code=6; key_held=1 within 3 frames plus 3 cycles.
- Bounce: the row 1/col 2 press toggles each frame for 5 frames, then holds -> no event during toggling, one event key_code=6 after 2 stable frames.
- Multi-key: row 0 col 0 and row 3 col 3 pressed together -> key_multi=1, no event. Release row 3 col 3 -> still no event (MULTI->SINGLE).
- Backpressure: key_ready=0; press code 1, release, press code 13 -> key_code stays 1 and overrun=1. Assert key_ready for 1 cycle -> key_valid=0 next cycle.
- Repeat (macro on, REPEAT_FRAMES=3): hold code 5 for 12 frames with key_ready=1 -> events at press, then every 3 frames, all with key_code=5.
